bcd_display_scanner: RTL and testbench

//  Time-multiplexed 7-segment driver for NUM_CH channels of DIG_PER_CH decimal digits each.

---
 rtl/bcd_display_scanner_if.sv | 16 +
 rtl/bcd_display_scanner.sv | 130 +++++++++++++
 tb/tb_bcd_display_scanner.sv | 120 ++++++++++++
 3 files changed

// File: rtl/bcd_display_scanner_if.sv
// bcd_display_scanner_if: value/handshake inputs and segment/anode outputs of the scanner
interface bcd_display_scanner_if #(
  parameter int NUM_CH     = 2,
  parameter int DIG_PER_CH = 4,
  parameter int IN_W       = 16
);
  localparam int N = NUM_CH * DIG_PER_CH;
  logic [NUM_CH*IN_W-1:0] Number;
  logic                   Load;
  logic [NUM_CH-1:0]      Blank_en;
  logic                   Busy;
  logic [6:0]             out7;
  logic [N-1:0]           en_out;
  modport master (output Number, Load, Blank_en, input Busy, out7, en_out);
  modport slave  (input Number, Load, Blank_en, output Busy, out7, en_out);
endinterface

// File: rtl/bcd_display_scanner.sv
// bcd_display_scanner: sequential double-dabble BCD conversion feeding a multiplexed 7-segment scan
module bcd_display_scanner #(
  parameter int NUM_CH     = 2,
  parameter int DIG_PER_CH = 4,
  parameter int IN_W       = 16,
  parameter int REFRESH_B  = 17
) (
  input logic Clk,
  input logic Rst_n,
  bcd_display_scanner_if.slave bus
);
  localparam int N     = NUM_CH * DIG_PER_CH;
  localparam int BCD_D = (IN_W * 3) / 10 + 2;
  localparam int BW    = (BCD_D > DIG_PER_CH ? BCD_D : DIG_PER_CH) + 1;
  localparam int CW    = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam int SW    = DIG_PER_CH > 1 ? $clog2(DIG_PER_CH) : 1;
  localparam int BIW   = $clog2(IN_W);
  localparam logic [CW-1:0]  CH_LAST = CW'(NUM_CH - 1);
  localparam logic [SW-1:0]  SD_LAST = SW'(DIG_PER_CH - 1);
  localparam logic [BIW-1:0] BI_LAST = BIW'(IN_W - 1);
  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;
  state_t                   state;
  logic [NUM_CH*IN_W-1:0]   sh;
  logic [IN_W-1:0]          bin, cur_bin, bin_nx;
  logic [BW*4-1:0]          bcd, cur_bcd, adj, bcd_nx;
  logic [CW-1:0]            ch, sc;
  logic [BIW-1:0]           bi;
  logic [SW-1:0]            sd;
  logic [DIG_PER_CH*4-1:0]  pend [NUM_CH];
  logic [DIG_PER_CH*4-1:0]  disp [NUM_CH];
  logic [DIG_PER_CH*4-1:0]  hi;
  logic [NUM_CH-1:0]        povf, ovf;
  logic [REFRESH_B-1:0]     presc;
  logic [N-1:0]             ring;
  logic [3:0]               cur_d;
  logic [6:0]               dec, seg;
  logic                     blank;
  // one double-dabble step: a new channel starts from its shadow value with a cleared BCD register
  always_comb begin
    cur_bcd = bi == '0 ? '0 : bcd;
    cur_bin = bi == '0 ? sh[ch*IN_W +: IN_W] : bin;
    adj = '0;
    for (int i = 0; i < BW; i++)
      adj[i*4 +: 4] = cur_bcd[i*4 +: 4] >= 4'd5 ? cur_bcd[i*4 +: 4] + 4'd3 : cur_bcd[i*4 +: 4];
    {bcd_nx, bin_nx} = {adj, cur_bin} << 1;
  end
  // capture, convert every channel into a pending buffer, then commit all channels at once
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state <= IDLE;
      bus.Busy <= 1'b0;
      sh <= '0;
      bin <= '0;
      bcd <= '0;
      ch <= '0;
      bi <= '0;
      ovf <= '0;
      povf <= '0;
      for (int i = 0; i < NUM_CH; i++) disp[i] <= '0;
    end else begin
      case (state)
        IDLE: if (bus.Load) begin
          sh <= bus.Number;
          ch <= '0;
          bi <= '0;
          bus.Busy <= 1'b1;
          state <= CONV;
        end
        CONV: begin
          bcd <= bcd_nx;
          bin <= bin_nx;
          bi <= bi == BI_LAST ? '0 : bi + 1'b1;
          if (bi == BI_LAST) begin
            pend[ch] <= bcd_nx[DIG_PER_CH*4-1:0];
            povf[ch] <= |bcd_nx[BW*4-1:DIG_PER_CH*4];
            ch <= ch + 1'b1;
            if (ch == CH_LAST) state <= COMMIT;
          end
        end
        COMMIT: begin
          disp <= pend;
          ovf <= povf;
          bus.Busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  // pick the digit under the scan position and apply overflow dash / leading-zero blanking
  always_comb begin
    cur_d = disp[sc][{sd, 2'b00} +: 4];
    hi = disp[sc] >> {sd, 2'b00};
    blank = bus.Blank_en[sc] && sd != '0 && hi == '0;
    case (cur_d)
      4'd0: dec = 7'b0000001;
      4'd1: dec = 7'b1001111;
      4'd2: dec = 7'b0010010;
      4'd3: dec = 7'b0000110;
      4'd4: dec = 7'b1001100;
      4'd5: dec = 7'b0100100;
      4'd6: dec = 7'b0100000;
      4'd7: dec = 7'b0001111;
      4'd8: dec = 7'b0000000;
      4'd9: dec = 7'b0000100;
      default: dec = 7'h7F;
    endcase
    seg = ovf[sc] ? 7'b1111110 : blank ? 7'h7F : dec;
  end
  // prescaled digit scan; the one-hot ring plus channel/digit counters avoid any divide
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      presc <= '0;
      ring <= N'(1);
      sc <= '0;
      sd <= '0;
      bus.en_out <= '1;
      bus.out7 <= 7'h7F;
    end else begin
      presc <= presc + 1'b1;
      if (&presc) begin
        ring <= (ring << 1) | (ring >> (N - 1));
        sd <= sd == SD_LAST ? '0 : sd + 1'b1;
        if (sd == SD_LAST) sc <= sc == CH_LAST ? '0 : sc + 1'b1;
      end
      bus.en_out <= ~ring;
      bus.out7 <= seg;
    end
  end
endmodule

// File: tb/tb_bcd_display_scanner.sv
// tb_bcd_display_scanner: directed checks of reset, conversion, blanking, overflow, handshake and scan wrap
module tb_bcd_display_scanner;
  localparam logic [6:0] S0 = 7'b0000001, S1 = 7'b1001111, S2 = 7'b0010010, S3 = 7'b0000110;
  localparam logic [6:0] S4 = 7'b1001100, S5 = 7'b0100100, BL = 7'h7F, DS = 7'b1111110;
  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  bcd_display_scanner_if #(.NUM_CH(2), .DIG_PER_CH(4), .IN_W(16)) b();
  bcd_display_scanner_if #(.NUM_CH(3), .DIG_PER_CH(1), .IN_W(8)) b2();
  bcd_display_scanner #(.NUM_CH(2), .DIG_PER_CH(4), .IN_W(16), .REFRESH_B(2)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .bus(b.slave));
  bcd_display_scanner #(.NUM_CH(3), .DIG_PER_CH(1), .IN_W(8), .REFRESH_B(2)) dut2 (
    .Clk(Clk), .Rst_n(Rst_n), .bus(b2.slave));
  always #5 Clk = ~Clk;
  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic busy_len(input string tag, input int exp);
    int n = 0;
    while (b.Busy === 1'b1 && n < 100) begin
      n++;
      tick(1);
    end
    chk(tag, n, exp);
  endtask
  task automatic scan(input string tag, input logic [55:0] e);
    int n = 0;
    logic [7:0] ex;
    while (b.en_out == 8'hFE && n < 40) begin tick(1); n++; end
    while (b.en_out != 8'hFE && n < 80) begin tick(1); n++; end
    for (int k = 0; k < 8; k++) begin
      ex = ~(8'd1 << k);
      chk($sformatf("%s_en%0d", tag, k), b.en_out, ex);
      chk($sformatf("%s_seg%0d", tag, k), b.out7, e[k*7 +: 7]);
      tick(4);
    end
    chk({tag, "_wrap"}, b.en_out, 8'hFE);
  endtask
  initial begin
    int n;
    b.Number = '0; b.Load = 1'b0; b.Blank_en = 2'b11;
    b2.Number = '0; b2.Load = 1'b0; b2.Blank_en = '0;
    tick(3);
    chk("rst_en", b.en_out, 8'hFF);
    chk("rst_seg", b.out7, BL);
    chk("rst_busy", b.Busy, 1'b0);
    Rst_n = 1'b1;
    tick(1);
    chk("rel_en", b.en_out, 8'hFE);
    chk("rel_seg", b.out7, S0);
    b.Number = {16'd42, 16'd1234};
    b.Load = 1'b1;
    tick(1);
    b.Load = 1'b0;
    b.Number = '0;
    chk("load_busy", b.Busy, 1'b1);
    busy_len("busy_len", 33);
    scan("v1234", {BL, BL, S4, S2, S1, S2, S3, S4});
    b.Blank_en = 2'b00;
    scan("noblank", {S0, S0, S4, S2, S1, S2, S3, S4});
    b.Blank_en = 2'b11;
    b.Number = {16'd42, 16'd10000};
    b.Load = 1'b1;
    tick(1);
    b.Load = 1'b0;
    tick(5);
    b.Number = {16'd99, 16'd5};
    b.Load = 1'b1;
    tick(1);
    b.Load = 1'b0;
    chk("ign_busy", b.Busy, 1'b1);
    busy_len("ign_len", 27);
    scan("ovf", {BL, BL, S4, S2, DS, DS, DS, DS});
    b.Number = {16'd1, 16'd1};
    b.Load = 1'b1;
    tick(1);
    b.Load = 1'b0;
    tick(9);
    Rst_n = 1'b0;
    tick(1);
    chk("abort_busy", b.Busy, 1'b0);
    chk("abort_en", b.en_out, 8'hFF);
    chk("abort_seg", b.out7, BL);
    Rst_n = 1'b1;
    tick(60);
    chk("abort_idle", b.Busy, 1'b0);
    scan("cleared", {BL, BL, BL, S0, BL, BL, BL, S0});
    b2.Number = {8'd0, 8'd12, 8'd5};
    b2.Load = 1'b1;
    tick(1);
    b2.Load = 1'b0;
    n = 0;
    while (b2.Busy === 1'b1 && n < 100) begin n++; tick(1); end
    chk("b2_len", n, 25);
    n = 0;
    while (b2.en_out == 3'b110 && n < 20) begin tick(1); n++; end
    while (b2.en_out != 3'b110 && n < 40) begin tick(1); n++; end
    chk("b2_en0", b2.en_out, 3'b110);
    chk("b2_seg0", b2.out7, S5);
    tick(4);
    chk("b2_en1", b2.en_out, 3'b101);
    chk("b2_seg1", b2.out7, DS);
    tick(4);
    chk("b2_en2", b2.en_out, 3'b011);
    chk("b2_seg2", b2.out7, S0);
    tick(4);
    chk("b2_wrap", b2.en_out, 3'b110);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
